// File: rtl/if_id_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// if_id_fetch_queue_if
//   Bundles the fetch-side and decode-side handshake signals of the IF/ID
//   instruction queue.
//
//   Fetch side : fetch_valid, fetch_instr, fetch_pc (to queue), fetch_ready (from queue)
//   Control    : flush (to queue), overflow_err (from queue)
//   Decode side: id_ready (to queue), id_valid, id_instr, id_pc, id_pc_plus4,
//                id_opcode, id_rs, id_rt, id_rd, id_imm (from queue)
//
//   Modports:
//     slave  - the queue itself (consumes fetch words, produces the decode head)
//     master - the surrounding pipeline / testbench driving the queue
// ----------------------------------------------------------------------------
interface if_id_fetch_queue_if;

    // Fetch stage -> queue
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;

    // Branch resolution -> queue
    logic        flush;

    // Queue -> decode stage
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_imm;

    // Sticky error status
    logic        overflow_err;

    modport slave (
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        output fetch_ready,
        input  flush,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output id_opcode,
        output id_rs,
        output id_rt,
        output id_rd,
        output id_imm,
        output overflow_err
    );

    modport master (
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        input  fetch_ready,
        output flush,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  id_opcode,
        input  id_rs,
        input  id_rt,
        input  id_rd,
        input  id_imm,
        input  overflow_err
    );

endinterface

// File: rtl/if_id_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_id_fetch_queue
//   Instruction queue between the fetch and decode stages. Fetched words and
//   their PCs are buffered in a DEPTH-entry circular buffer and presented to
//   decode over a valid/ready handshake. A taken-branch flush discards every
//   buffered word. The head instruction is also split into MIPS fields.
//
//   Ports:
//     clk    - rising-edge clock shared with fetch
//     rst_n  - asynchronous active-low reset
//     bus    - if_id_fetch_queue_if.slave (fetch handshake, flush,
//              decode handshake and head fields, overflow_err)
//
//   Parameters:
//     DEPTH    - buffered entries, power of two, >= 2
//     NOP_WORD - word shown on id_instr while the queue is empty
// ----------------------------------------------------------------------------
module if_id_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_id_fetch_queue_if.slave    bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("if_id_fetch_queue: DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic          fetch_ready_w;
    logic          head_valid_w;
    logic          push_w;
    logic          pop_w;

    logic [31:0]   head_instr_w;
    logic [31:0]   head_pc_w;
    logic [31:0]   head_pc_plus4_w;

    // ------------------------------------------------------------------
    // Handshake qualification. fetch_ready and id_valid come only from
    // registered occupancy, so id_ready never reaches fetch_ready
    // combinationally; a full queue cannot accept even while popping.
    // ------------------------------------------------------------------
    always_comb begin
        fetch_ready_w = (count_q < FULL_CNT);
        head_valid_w  = (count_q != '0);
        push_w        = bus.fetch_valid && fetch_ready_w;
        pop_w         = head_valid_w && bus.id_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush has priority over push and pop
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        // A refused word is an overflow regardless of flush
        overflow_d = overflow_q | (bus.fetch_valid & ~fetch_ready_w);

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_w, pop_w})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry payload needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push_w && !bus.flush) begin
            instr_mem_q[wr_ptr_q] <= bus.fetch_instr;
            pc_mem_q[wr_ptr_q]    <= bus.fetch_pc;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation; empty queue shows the NOP word and zero PCs
    // ------------------------------------------------------------------
    always_comb begin
        head_instr_w    = NOP_WORD;
        head_pc_w       = '0;
        head_pc_plus4_w = '0;
        if (head_valid_w) begin
            head_instr_w    = instr_mem_q[rd_ptr_q];
            head_pc_w       = pc_mem_q[rd_ptr_q];
            head_pc_plus4_w = pc_mem_q[rd_ptr_q] + 32'd4;
        end
    end

    assign bus.fetch_ready  = fetch_ready_w;
    assign bus.id_valid     = head_valid_w;
    assign bus.id_instr     = head_instr_w;
    assign bus.id_pc        = head_pc_w;
    assign bus.id_pc_plus4  = head_pc_plus4_w;
    assign bus.id_opcode    = head_instr_w[31:26];
    assign bus.id_rs        = head_instr_w[25:21];
    assign bus.id_rt        = head_instr_w[20:16];
    assign bus.id_rd        = head_instr_w[15:11];
    assign bus.id_imm       = head_instr_w[15:0];
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_fetch_queue
//   Directed self-checking bench for if_id_fetch_queue (DEPTH=2, NOP_WORD=0).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_if_id_fetch_queue;

    logic clk;
    logic rst_n;

    int unsigned n_cmp;
    int unsigned n_err;

    if_id_fetch_queue_if bus ();

    if_id_fetch_queue #(
        .DEPTH    (2),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bus.fetch_valid = fv;
        bus.fetch_instr = instr;
        bus.fetch_pc    = pc;
        bus.id_ready    = rdy;
        bus.flush       = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // ---------------- reset then idle ----------------
        tick();
        check_eq("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check_eq("rst_id_valid",    32'(bus.id_valid),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("idle_fetch_ready", 32'(bus.fetch_ready),  32'd1);
        check_eq("idle_id_valid",    32'(bus.id_valid),     32'd0);
        check_eq("idle_id_instr",    bus.id_instr,          32'h0);
        check_eq("idle_id_pc",       bus.id_pc,             32'h0);
        check_eq("idle_id_pc4",      bus.id_pc_plus4,       32'h0);
        check_eq("idle_ovf",         32'(bus.overflow_err), 32'd0);

        // ---------------- single transfer ----------------
        // id_ready high while empty must not pop anything
        drive(1'b1, 32'h8C08_0004, 32'h40, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("xfer_valid",  32'(bus.id_valid),  32'd1);
        check_eq("xfer_instr",  bus.id_instr,       32'h8C08_0004);
        check_eq("xfer_opcode", 32'(bus.id_opcode), 32'h23);
        check_eq("xfer_rs",     32'(bus.id_rs),     32'd0);
        check_eq("xfer_rt",     32'(bus.id_rt),     32'd8);
        check_eq("xfer_rd",     32'(bus.id_rd),     32'd0);
        check_eq("xfer_imm",    32'(bus.id_imm),    32'h0004);
        check_eq("xfer_pc",     bus.id_pc,          32'h40);
        check_eq("xfer_pc4",    bus.id_pc_plus4,    32'h44);
        tick();
        check_eq("xfer_drain_valid", 32'(bus.id_valid), 32'd0);
        check_eq("xfer_drain_opc",   32'(bus.id_opcode), 32'd0);

        // ---------------- stall fill and overflow ----------------
        drive(1'b1, 32'h2001_0011, 32'h00, 1'b0, 1'b0);
        tick();
        check_eq("fill1_ready", 32'(bus.fetch_ready), 32'd1);
        drive(1'b1, 32'h2002_0022, 32'h04, 1'b0, 1'b0);
        tick();
        check_eq("fill2_ready", 32'(bus.fetch_ready),  32'd0);
        check_eq("fill2_pc",    bus.id_pc,             32'h00);
        check_eq("fill2_ovf",   32'(bus.overflow_err), 32'd0);
        drive(1'b1, 32'h2003_0033, 32'h08, 1'b0, 1'b0);
        tick();
        check_eq("ovf_set",   32'(bus.overflow_err), 32'd1);
        check_eq("ovf_pc",    bus.id_pc,             32'h00);
        check_eq("ovf_instr", bus.id_instr,          32'h2001_0011);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_eq("drain_pc1",    bus.id_pc,            32'h04);
        check_eq("drain_instr1", bus.id_instr,         32'h2002_0022);
        check_eq("drain_ready1", 32'(bus.fetch_ready), 32'd1);
        tick();
        check_eq("drain_empty",  32'(bus.id_valid),    32'd0);
        check_eq("ovf_sticky",   32'(bus.overflow_err), 32'd1);

        // ---------------- simultaneous push/pop at occupancy 1 ----------------
        drive(1'b1, 32'hA000_0000, 32'h00, 1'b1, 1'b0);
        tick();
        check_eq("pp_pc0", bus.id_pc, 32'h00);
        for (int i = 1; i < 6; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 1'b1, 1'b0);
            tick();
            check_eq($sformatf("pp_pc%0d", i),    bus.id_pc,            32'(4 * i));
            check_eq($sformatf("pp_instr%0d", i), bus.id_instr,         32'hA000_0000 + 32'(i));
            check_eq($sformatf("pp_ready%0d", i), 32'(bus.fetch_ready), 32'd1);
            check_eq($sformatf("pp_valid%0d", i), 32'(bus.id_valid),    32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_eq("pp_end_empty", 32'(bus.id_valid), 32'd0);

        // ---------------- flush ----------------
        drive(1'b1, 32'hB000_0200, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB000_0204, 32'h204, 1'b0, 1'b0);
        tick();
        check_eq("fl_full", 32'(bus.fetch_ready), 32'd0);
        drive(1'b1, 32'hB000_0208, 32'h208, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("fl_valid", 32'(bus.id_valid),    32'd0);
        check_eq("fl_ready", 32'(bus.fetch_ready), 32'd1);
        check_eq("fl_instr", bus.id_instr,         32'h0);
        drive(1'b1, 32'hC000_0100, 32'h100, 1'b0, 1'b0);
        tick();
        check_eq("fl_next_valid", 32'(bus.id_valid), 32'd1);
        check_eq("fl_next_pc",    bus.id_pc,         32'h100);
        check_eq("fl_next_instr", bus.id_instr,      32'hC000_0100);
        // flush with an acceptable push and a pop in the same cycle
        drive(1'b1, 32'hC000_0104, 32'h104, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("fl2_valid", 32'(bus.id_valid),    32'd0);
        check_eq("fl2_ready", 32'(bus.fetch_ready), 32'd1);
        check_eq("fl2_ovf",   32'(bus.overflow_err), 32'd1);

        // ---------------- async reset mid-stream ----------------
        drive(1'b1, 32'hD000_0000, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hD000_0004, 32'h304, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("ar_pre_valid", 32'(bus.id_valid),    32'd1);
        check_eq("ar_pre_ready", 32'(bus.fetch_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 32'(bus.id_valid),     32'd0);
        check_eq("ar_ready", 32'(bus.fetch_ready),  32'd1);
        check_eq("ar_pc",    bus.id_pc,             32'h0);
        check_eq("ar_ovf",   32'(bus.overflow_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("ar_post_valid", 32'(bus.id_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
